// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the two-port SDRAM arbiter and the blocks that feed it.
package sdram_arb_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    RELEASE
  } state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // A lone requester always wins; on a tie the port that was not served last wins.
  function automatic port_e rr_pick(input logic req0, input logic req1, input port_e last);
    if (req0 && req1) return (last == PORT0) ? PORT1 : PORT0;
    return req1 ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Requester ports and sdram_ctl handshake of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters plus the controller.
interface sdram_arb_if;
  import sdram_arb_pkg::*;

  logic              p0_req, p1_req;
  logic              p0_rw, p1_rw;
  logic              p0_u_n, p0_l_n, p1_u_n, p1_l_n;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_ack, p1_ack;
  logic              p0_err, p1_err;
  logic [DATA_W-1:0] rdata;

  logic              ctl_ena, ctl_rw, ctl_u_n, ctl_l_n;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_ready;
  logic [DATA_W-1:0] ctl_rdata;

  modport slave (
    input  p0_req, p1_req, p0_rw, p1_rw, p0_u_n, p0_l_n, p1_u_n, p1_l_n,
    input  p0_addr, p1_addr, p0_wdata, p1_wdata,
    output p0_ack, p1_ack, p0_err, p1_err, rdata,
    output ctl_ena, ctl_rw, ctl_u_n, ctl_l_n, ctl_addr, ctl_wdata,
    input  ctl_ready, ctl_rdata
  );

  modport master (
    output p0_req, p1_req, p0_rw, p1_rw, p0_u_n, p0_l_n, p1_u_n, p1_l_n,
    output p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  p0_ack, p1_ack, p0_err, p1_err, rdata,
    input  ctl_ena, ctl_rw, ctl_u_n, ctl_l_n, ctl_addr, ctl_wdata,
    output ctl_ready, ctl_rdata
  );

endinterface

// File: rtl/sdram_arb.sv
// Round-robin arbiter between two requesters in front of sdram_ctl; sequences the
// ena/ready handshake one access at a time and aborts with err if ready never comes.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input logic        clk,
  input logic        reset_n,
  sdram_arb_if.slave bus
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_e            state;
  port_e             last;
  port_e             pick;
  logic [7:0]        wait_cnt;

  logic              sel_rw, sel_u_n, sel_l_n;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // NOTE: every branch assigns every output of this block, so no latch is inferred.
  always_comb begin
    pick = rr_pick(bus.p0_req, bus.p1_req, last);
    if (pick == PORT1) begin
      sel_rw    = bus.p1_rw;
      sel_u_n   = bus.p1_u_n;
      sel_l_n   = bus.p1_l_n;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end else begin
      sel_rw    = bus.p0_rw;
      sel_u_n   = bus.p0_u_n;
      sel_l_n   = bus.p0_l_n;
      sel_addr  = bus.p0_addr;
      sel_wdata = bus.p0_wdata;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees
  // pre-edge values; reset is synchronous, tested before anything else in the block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      last          <= PORT1;
      wait_cnt      <= '0;
      bus.ctl_ena   <= 1'b0;
      bus.ctl_rw    <= 1'b1;
      bus.ctl_u_n   <= 1'b1;
      bus.ctl_l_n   <= 1'b1;
      bus.ctl_addr  <= '0;
      bus.ctl_wdata <= '0;
      bus.rdata     <= '0;
      bus.p0_ack    <= 1'b0;
      bus.p1_ack    <= 1'b0;
      bus.p0_err    <= 1'b0;
      bus.p1_err    <= 1'b0;
    end else begin
      bus.p0_ack <= 1'b0;
      bus.p1_ack <= 1'b0;
      bus.p0_err <= 1'b0;
      bus.p1_err <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.p0_req || bus.p1_req) begin
            bus.ctl_rw    <= sel_rw;
            bus.ctl_u_n   <= sel_u_n;
            bus.ctl_l_n   <= sel_l_n;
            bus.ctl_addr  <= sel_addr;
            bus.ctl_wdata <= sel_wdata;
            bus.ctl_ena   <= 1'b1;
            last          <= pick;
            wait_cnt      <= '0;
            state         <= WAIT_RDY;
          end
        end

        WAIT_RDY: begin
          if (bus.ctl_ready) begin
            if (bus.ctl_rw) bus.rdata <= bus.ctl_rdata;
            bus.p0_ack  <= (last == PORT0);
            bus.p1_ack  <= (last == PORT1);
            bus.ctl_ena <= 1'b0;
            state       <= RELEASE;
          end else if (wait_cnt >= WAIT_LIM) begin
            bus.p0_ack  <= (last == PORT0);
            bus.p1_ack  <= (last == PORT1);
            bus.p0_err  <= (last == PORT0);
            bus.p1_err  <= (last == PORT1);
            bus.ctl_ena <= 1'b0;
            state       <= RELEASE;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        // Requests are ignored until the controller drops ready, so a requester
        // still holding req in the ack cycle is not served twice.
        RELEASE: begin
          if (!bus.ctl_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
